// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: funct3 branch codes and
// 2-bit saturating counter encodings used by the BHT.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RST = WNT;

  function automatic bht_cnt_e sat_update(input bht_cnt_e c, input logic taken);
    if (taken) return (c == ST)  ? ST  : bht_cnt_e'(c + 2'd1);
    else       return (c == SNT) ? SNT : bht_cnt_e'(c - 2'd1);
  endfunction

  // 010/011 are reserved encodings in the branch opcode space
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch, one synchronous update port for resolution (no bypass).
module bht_2bit
  import branch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  bht_cnt_e [DEPTH-1:0] r_cnt;

  assign o_rd_cnt = r_cnt[i_rd_idx];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        r_cnt[g] <= BHT_RST;
      else if (i_wr_en && (i_wr_idx == IDX_W'(g)))
        r_cnt[g] <= sat_update(r_cnt[g], i_wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: condition evaluation, BHT training, registered
// one-cycle redirect on mispredict, and branch/mispredict perf counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_is_branch,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic             ex_pred_taken,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal_branch,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic             r_redirect_valid;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  logic             w_resolve;
  logic             w_legal;
  logic             w_taken;
  logic             w_mispredict;
  logic [XLEN-1:0]  w_target;
  logic [XLEN-1:0]  w_fallthru;
  logic [1:0]       w_if_cnt;
  logic             w_unused;

  // Only the index bits of the fetch PC address the table
  assign w_unused = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

  // The instruction right behind a redirect is wrong-path and must not resolve
  assign w_resolve    = ex_valid & ex_is_branch & ~ex_stall & ~r_redirect_valid;
  assign w_legal      = f3_legal(ex_funct3);
  assign w_mispredict = w_resolve & (w_taken ^ ex_pred_taken);
  assign w_target     = ex_pc + ex_imm;
  assign w_fallthru   = ex_pc + XLEN'(4);

  always_comb begin
    w_taken = 1'b0;
    case (ex_funct3)
      F3_BEQ:  w_taken = (ex_rs1 == ex_rs2);
      F3_BNE:  w_taken = (ex_rs1 != ex_rs2);
      F3_BLT:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      F3_BGE:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      F3_BLTU: w_taken = (ex_rs1 <  ex_rs2);
      F3_BGEU: w_taken = (ex_rs1 >= ex_rs2);
      default: w_taken = 1'b0;
    endcase
  end

  bht_2bit #(.DEPTH(BHT_DEPTH)) u_bht (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rd_idx   (if_pc[IDX_W+1:2]),
    .o_rd_cnt   (w_if_cnt),
    .i_wr_en    (w_resolve & w_legal),
    .i_wr_idx   (ex_pc[IDX_W+1:2]),
    .i_wr_taken (w_taken)
  );

  assign if_pred_taken = w_if_cnt[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_redirect_valid   <= 1'b0;
      r_redirect_pc      <= '0;
      r_illegal          <= 1'b0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_illegal        <= w_resolve & ~w_legal;
      if (w_mispredict) begin
        r_redirect_pc      <= w_taken ? w_target : w_fallthru;
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
      if (w_resolve && w_legal)
        r_branch_count <= r_branch_count + CNT_W'(1);
    end
  end

  assign redirect_valid   = r_redirect_valid;
  assign redirect_pc      = r_redirect_pc;
  assign illegal_branch   = r_illegal;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
